// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: shared encodings and result-slice helper for mul_ctrl
//   REG_BUS      : data path width (64)
//   MULOP_*      : in_op encodings (funct3[1:0])
//   mulc_state_t : sequencer states IDLE/RUN/DONE/DRAIN
//   mul_sel_result: picks and extends the architectural result from the 128-bit product
package mul_ctrl_pkg;
    localparam int REG_BUS = 64;
    localparam logic [1:0] MULOP_MUL    = 2'b00;
    localparam logic [1:0] MULOP_MULH   = 2'b01;
    localparam logic [1:0] MULOP_MULHSU = 2'b10;
    localparam logic [1:0] MULOP_MULHU  = 2'b11;
    typedef enum logic [1:0] {
        MULC_IDLE,
        MULC_RUN,
        MULC_DONE,
        MULC_DRAIN
    } mulc_state_t;
    function automatic logic [REG_BUS-1:0] mul_sel_result(
        input logic [1:0]           op,
        input logic                 word,
        input logic [2*REG_BUS-1:0] res
    );
        return word ? {{32{res[31]}}, res[31:0]} :
               (op == MULOP_MUL) ? res[REG_BUS-1:0] : res[2*REG_BUS-1:REG_BUS];
    endfunction
endpackage

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer between EXE and the radix-4 Booth multiplier (booth2_mul)
//   in_*  : op request handshake (in_valid/in_ready), op, MULW flag, operands
//   flush : kills the op in flight (priority over accept and out_ready)
//   out_* : result handshake (out_valid/out_ready), 64-bit result
//   mul_* : multiplier interface (level valid, signs, registered operands, ready, product)
//   mul_err: sticky watchdog error, cleared only by rst
// Optional feature: define MUL_ZERO_BYPASS_EN to complete ops with a zero operand in one
// cycle without starting the multiplier.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic                 in_word,
    input  logic [REG_BUS-1:0]   in_rs1,
    input  logic [REG_BUS-1:0]   in_rs2,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_BUS-1:0]   out_data,
    output logic                 mul_valid,
    output logic                 mul_rs1_sign,
    output logic                 mul_rs2_sign,
    output logic [REG_BUS-1:0]   mul_rs1_data,
    output logic [REG_BUS-1:0]   mul_rs2_data,
    input  logic                 mul_ready,
    input  logic [2*REG_BUS-1:0] mul_result,
    output logic                 mul_err
);
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    mulc_state_t        r_state, w_next;
    logic [1:0]         r_op;
    logic               r_word, r_s1, r_s2, r_err;
    logic [REG_BUS-1:0] r_rs1, r_rs2, r_out;
    logic [WDW-1:0]     r_wdog;
    logic [REG_BUS-1:0] w_rs1_eff, w_rs2_eff;
    logic               w_accept, w_zero, w_busy, w_wdog_hit, w_capture;

    assign w_rs1_eff = in_word ? {32'b0, in_rs1[31:0]} : in_rs1;
    assign w_rs2_eff = in_word ? {32'b0, in_rs2[31:0]} : in_rs2;
`ifdef MUL_ZERO_BYPASS_EN
    assign w_zero = ~|w_rs1_eff | ~|w_rs2_eff;
`else
    assign w_zero = 1'b0;
`endif
    assign w_busy     = (r_state == MULC_RUN) | (r_state == MULC_DRAIN);
    // a late mul_ready on the limit cycle still counts as a normal finish
    assign w_wdog_hit = w_busy & ~mul_ready & (r_wdog >= WDW'(WDOG_CYCLES - 1));
    assign in_ready   = ~flush & ((r_state == MULC_IDLE) | ((r_state == MULC_DONE) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_capture  = (r_state == MULC_RUN) & mul_ready & ~flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            MULC_IDLE:  w_next = w_accept ? (w_zero ? MULC_DONE : MULC_RUN) : MULC_IDLE;
            MULC_RUN:   w_next = w_wdog_hit ? MULC_IDLE :
                                 flush      ? (mul_ready ? MULC_IDLE : MULC_DRAIN) :
                                 mul_ready  ? MULC_DONE : MULC_RUN;
            MULC_DONE:  w_next = w_accept ? (w_zero ? MULC_DONE : MULC_RUN) :
                                 (flush | out_ready) ? MULC_IDLE : MULC_DONE;
            MULC_DRAIN: w_next = (mul_ready | w_wdog_hit) ? MULC_IDLE : MULC_DRAIN;
            default:    w_next = MULC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MULC_IDLE;
            r_op    <= '0;
            r_word  <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_out   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            // counts only consecutive RUN/DRAIN cycles of one op; DONE->RUN restarts at 0
            r_wdog  <= (w_busy & ((w_next == MULC_RUN) | (w_next == MULC_DRAIN))) ? r_wdog + WDW'(1) : '0;
            r_err   <= r_err | w_wdog_hit;
            if (w_accept) begin
                r_op   <= in_op;
                r_word <= in_word;
                r_rs1  <= w_rs1_eff;
                r_rs2  <= w_rs2_eff;
                r_s1   <= ~in_word & in_rs1[REG_BUS-1] & ((in_op == MULOP_MULH) | (in_op == MULOP_MULHSU));
                r_s2   <= ~in_word & in_rs2[REG_BUS-1] & (in_op == MULOP_MULH);
            end
            if (w_capture)
                r_out <= mul_sel_result(r_op, r_word, mul_result);
            else if (w_accept & w_zero)
                r_out <= '0;
        end
    end

    assign out_valid    = r_state == MULC_DONE;
    assign out_data     = r_out;
    assign mul_valid    = w_busy;
    assign mul_rs1_sign = r_s1;
    assign mul_rs2_sign = r_s2;
    assign mul_rs1_data = r_rs1;
    assign mul_rs2_data = r_rs2;
    assign mul_err      = r_err;
endmodule
